// File: rtl/integrator_mc_pkg.sv
// Shared constants and signed-range helpers for the multi-channel integrator.
package integrator_mc_pkg;

    localparam int LEAK_SH_W = 5;

    function automatic longint smax(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint smin(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/integ_sat_add.sv
// Saturating y = a + b - c on W-bit signed operands, with overflow flag.
module integ_sat_add
    import integrator_mc_pkg::*;
#(
    parameter int W = 28
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    localparam logic signed [W+1:0] MAX = (W+2)'(smax(W));
    localparam logic signed [W+1:0] MIN = (W+2)'(smin(W));

    logic signed [W+1:0] sum;

    // Two guard bits hold a + b - c exactly before clipping.
    always_comb begin
        sum = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b})
            - $signed({{2{c[W-1]}}, c});
        ovf = 1'b0;
        y   = sum[W-1:0];
        if (sum > MAX) begin
            y   = MAX[W-1:0];
            ovf = 1'b1;
        end else if (sum < MIN) begin
            y   = MIN[W-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/integrator_mc.sv
// Multi-channel saturating leaky integrator, one-cycle latency.
// Leak shifter is built only when INTEGRATOR_MC_LEAK_EN is defined.
module integrator_mc
    import integrator_mc_pkg::*;
#(
    parameter int DATA_W = 22,
    parameter int ACC_W  = 28,
    parameter int N_CH   = 4,
    parameter int OUT_SH = 4,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     clr,
    input  logic [CH_W-1:0]          clr_ch,
    input  logic [LEAK_SH_W-1:0]     leak_sh,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    output logic [N_CH-1:0]          sat_flags
);

    localparam logic [CH_W:0]             NCH  = (CH_W+1)'(N_CH);
    localparam logic signed [ACC_W-1:0]   DMAX = ACC_W'(smax(DATA_W));
    localparam logic signed [ACC_W-1:0]   DMIN = ACC_W'(smin(DATA_W));

    logic signed [ACC_W-1:0] acc [N_CH];
    logic [N_CH-1:0]         sat_q;

    logic                    in_ok, clr_ok, same;
    logic signed [ACC_W-1:0] cur, base, sample, leak, nxt, shifted;
    logic signed [DATA_W-1:0] out_next;
    logic                    acc_ovf, out_clip;

    assign in_ok  = in_valid && ({1'b0, in_ch} < NCH);
    assign clr_ok = clr && ({1'b0, clr_ch} < NCH);
    assign same   = in_ok && clr_ok && (clr_ch == in_ch);

    // Mux read keeps out-of-range channel codes from indexing the array.
    always_comb begin
        cur = '0;
        for (int i = 0; i < N_CH; i++)
            if (in_ch == CH_W'(i)) cur = acc[i];
    end

    assign base   = same ? '0 : cur;
    assign sample = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

`ifdef INTEGRATOR_MC_LEAK_EN
    assign leak = (leak_sh != '0) ? (base >>> leak_sh) : '0;
`else
    logic unused_leak_sh;
    assign unused_leak_sh = ^leak_sh;
    assign leak = '0;
`endif

    integ_sat_add #(.W(ACC_W)) u_add (
        .a   (base),
        .b   (sample),
        .c   (leak),
        .y   (nxt),
        .ovf (acc_ovf)
    );

    assign shifted = nxt >>> OUT_SH;

    always_comb begin
        out_clip = 1'b0;
        out_next = shifted[DATA_W-1:0];
        if (shifted > DMAX) begin
            out_next = DMAX[DATA_W-1:0];
            out_clip = 1'b1;
        end else if (shifted < DMIN) begin
            out_next = DMIN[DATA_W-1:0];
            out_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
            sat_q     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= in_ok;
            if (in_ok) begin
                out_ch   <= in_ch;
                out_data <= out_next;
            end
            // A same-channel clear drops the old sticky flag before this sample's clip.
            for (int i = 0; i < N_CH; i++) begin
                if (in_ok && in_ch == CH_W'(i)) begin
                    acc[i]   <= nxt;
                    sat_q[i] <= (sat_q[i] & ~same) | acc_ovf | out_clip;
                end else if (clr_ok && clr_ch == CH_W'(i)) begin
                    acc[i]   <= '0;
                    sat_q[i] <= 1'b0;
                end
            end
        end
    end

    assign sat_flags = sat_q;

endmodule
